// File: rtl/rob_superscalar.sv
// Superscalar reorder buffer: multi-lane in-order dispatch and retire, CDB completion,
// operand lookup with same-cycle CDB bypass, and mispredict squash on retirement.
module rob_superscalar #(
    parameter int DEPTH     = 32,
    parameter int WIDTH     = 2,
    parameter int CDB_PORTS = 2,
    parameter int XLEN      = 32,
    localparam int TAG_W    = $clog2(DEPTH)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           dp_valid,
    input  logic [WIDTH*5-1:0]         dp_dest_reg,
    input  logic [WIDTH*XLEN-1:0]      dp_pc,
    output logic                       dp_ready,
    output logic [WIDTH*TAG_W-1:0]     dp_tag,
    input  logic [CDB_PORTS-1:0]       cdb_valid,
    input  logic [CDB_PORTS*TAG_W-1:0] cdb_tag,
    input  logic [CDB_PORTS*XLEN-1:0]  cdb_value,
    input  logic [CDB_PORTS*XLEN-1:0]  cdb_npc,
    input  logic [CDB_PORTS-1:0]       cdb_take_branch,
    input  logic [2*WIDTH*TAG_W-1:0]   src_tag,
    output logic [2*WIDTH*XLEN-1:0]    src_value,
    output logic [2*WIDTH-1:0]         src_ready,
    output logic [WIDTH-1:0]           rt_valid,
    output logic [WIDTH*5-1:0]         rt_dest_reg,
    output logic [WIDTH*XLEN-1:0]      rt_value,
    output logic [WIDTH*XLEN-1:0]      rt_pc,
    output logic                       squash,
    output logic [XLEN-1:0]            squash_pc,
    output logic [TAG_W:0]             count,
    output logic                       empty,
    output logic                       full
);

    logic [TAG_W-1:0] head;
    logic [TAG_W-1:0] tail;
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] complete_q;
    logic [DEPTH-1:0] branch_q;
    logic [4:0]       dest_q  [DEPTH];
    logic [XLEN-1:0]  pc_q    [DEPTH];
    logic [XLEN-1:0]  npc_q   [DEPTH];
    logic [XLEN-1:0]  value_q [DEPTH];

    logic [WIDTH-1:0] dp_go;
    logic [TAG_W:0]   dp_cnt;
    logic             dp_run;
    logic [TAG_W-1:0] rt_slot [WIDTH];
    logic [WIDTH-1:0] rt_go;
    logic [TAG_W:0]   rt_cnt;
    logic             rt_run;
    logic             sq;
    logic [XLEN-1:0]  sq_pc;

    assign empty    = (count == '0);
    assign full     = (count == (TAG_W+1)'(DEPTH));
    assign dp_ready = (((TAG_W+1)'(DEPTH) - count) >= (TAG_W+1)'(WIDTH));

    always_comb begin
        dp_tag = '0;
        dp_go  = '0;
        dp_cnt = '0;
        dp_run = dp_ready;
        for (int i = 0; i < WIDTH; i++) begin
            dp_tag[i*TAG_W +: TAG_W] = tail + TAG_W'(i);
            dp_run   = dp_run && dp_valid[i];
            dp_go[i] = dp_run;
            if (dp_run) dp_cnt = dp_cnt + (TAG_W+1)'(1);
        end
    end

    // Retirement stops at the first incomplete entry and after the first taken branch.
    always_comb begin
        rt_go  = '0;
        rt_cnt = '0;
        rt_run = 1'b1;
        sq     = 1'b0;
        sq_pc  = '0;
        rt_dest_reg = '0;
        rt_value    = '0;
        rt_pc       = '0;
        for (int i = 0; i < WIDTH; i++) begin
            rt_slot[i] = head + TAG_W'(i);
            rt_dest_reg[i*5 +: 5]  = dest_q[rt_slot[i]];
            rt_value[i*XLEN +: XLEN] = value_q[rt_slot[i]];
            rt_pc[i*XLEN +: XLEN]    = pc_q[rt_slot[i]];
            rt_run   = rt_run && valid_q[rt_slot[i]] && complete_q[rt_slot[i]];
            rt_go[i] = rt_run;
            if (rt_run) begin
                rt_cnt = rt_cnt + (TAG_W+1)'(1);
                if (branch_q[rt_slot[i]]) begin
                    sq    = 1'b1;
                    sq_pc = npc_q[rt_slot[i]];
                end
            end
            rt_run = rt_run && !branch_q[rt_slot[i]];
        end
    end

    assign rt_valid  = reset ? rt_go : '0;
    assign squash    = reset && sq;
    assign squash_pc = squash ? sq_pc : '0;

    always_comb begin
        src_ready = '0;
        src_value = '0;
        for (int s = 0; s < 2*WIDTH; s++) begin
            src_ready[s] = complete_q[src_tag[s*TAG_W +: TAG_W]];
            src_value[s*XLEN +: XLEN] = value_q[src_tag[s*TAG_W +: TAG_W]];
            for (int p = 0; p < CDB_PORTS; p++) begin
                if (cdb_valid[p] && cdb_tag[p*TAG_W +: TAG_W] == src_tag[s*TAG_W +: TAG_W]) begin
                    src_ready[s] = 1'b1;
                    src_value[s*XLEN +: XLEN] = cdb_value[p*XLEN +: XLEN];
                end
            end
        end
    end

    // Reset, flush and squash all empty the buffer; payload arrays need no clearing.
    always_ff @(posedge clock) begin
        if (!reset || flush || sq) begin
            valid_q    <= '0;
            complete_q <= '0;
            branch_q   <= '0;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
        end else begin
            for (int p = 0; p < CDB_PORTS; p++) begin
                if (cdb_valid[p] && valid_q[cdb_tag[p*TAG_W +: TAG_W]]) begin
                    complete_q[cdb_tag[p*TAG_W +: TAG_W]] <= 1'b1;
                    branch_q[cdb_tag[p*TAG_W +: TAG_W]]   <= cdb_take_branch[p];
                    value_q[cdb_tag[p*TAG_W +: TAG_W]]    <= cdb_value[p*XLEN +: XLEN];
                    npc_q[cdb_tag[p*TAG_W +: TAG_W]]      <= cdb_npc[p*XLEN +: XLEN];
                end
            end
            for (int i = 0; i < WIDTH; i++) begin
                if (rt_go[i]) begin
                    valid_q[rt_slot[i]]    <= 1'b0;
                    complete_q[rt_slot[i]] <= 1'b0;
                end
            end
            for (int i = 0; i < WIDTH; i++) begin
                if (dp_go[i]) begin
                    valid_q[tail + TAG_W'(i)]    <= 1'b1;
                    complete_q[tail + TAG_W'(i)] <= 1'b0;
                    branch_q[tail + TAG_W'(i)]   <= 1'b0;
                    dest_q[tail + TAG_W'(i)]     <= dp_dest_reg[i*5 +: 5];
                    pc_q[tail + TAG_W'(i)]       <= dp_pc[i*XLEN +: XLEN];
                end
            end
            head  <= head + rt_cnt[TAG_W-1:0];
            tail  <= tail + dp_cnt[TAG_W-1:0];
            count <= count + dp_cnt - rt_cnt;
        end
    end

endmodule

// File: tb/tb_rob_superscalar.sv
// Randomized and directed bench for rob_superscalar, checked against a queue-based model
// of the in-flight instruction window.
module tb_rob_superscalar;
    localparam int DEPTH     = 32;
    localparam int WIDTH     = 2;
    localparam int CDB_PORTS = 2;
    localparam int XLEN      = 32;
    localparam int TAG_W     = 5;
    localparam int NSRC      = 2*WIDTH;

    logic                       clock = 1'b0;
    logic                       reset;
    logic                       flush;
    logic [WIDTH-1:0]           dp_valid;
    logic [WIDTH*5-1:0]         dp_dest_reg;
    logic [WIDTH*XLEN-1:0]      dp_pc;
    logic                       dp_ready;
    logic [WIDTH*TAG_W-1:0]     dp_tag;
    logic [CDB_PORTS-1:0]       cdb_valid;
    logic [CDB_PORTS*TAG_W-1:0] cdb_tag;
    logic [CDB_PORTS*XLEN-1:0]  cdb_value;
    logic [CDB_PORTS*XLEN-1:0]  cdb_npc;
    logic [CDB_PORTS-1:0]       cdb_take_branch;
    logic [NSRC*TAG_W-1:0]      src_tag;
    logic [NSRC*XLEN-1:0]       src_value;
    logic [NSRC-1:0]            src_ready;
    logic [WIDTH-1:0]           rt_valid;
    logic [WIDTH*5-1:0]         rt_dest_reg;
    logic [WIDTH*XLEN-1:0]      rt_value;
    logic [WIDTH*XLEN-1:0]      rt_pc;
    logic                       squash;
    logic [XLEN-1:0]            squash_pc;
    logic [TAG_W:0]             count;
    logic                       empty;
    logic                       full;

    always #5 clock = ~clock;

    rob_superscalar #(.DEPTH(DEPTH), .WIDTH(WIDTH), .CDB_PORTS(CDB_PORTS), .XLEN(XLEN)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .dp_valid(dp_valid), .dp_dest_reg(dp_dest_reg), .dp_pc(dp_pc),
        .dp_ready(dp_ready), .dp_tag(dp_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .cdb_npc(cdb_npc), .cdb_take_branch(cdb_take_branch),
        .src_tag(src_tag), .src_value(src_value), .src_ready(src_ready),
        .rt_valid(rt_valid), .rt_dest_reg(rt_dest_reg), .rt_value(rt_value), .rt_pc(rt_pc),
        .squash(squash), .squash_pc(squash_pc),
        .count(count), .empty(empty), .full(full)
    );

    typedef struct {
        int          tag;
        logic [4:0]  dest;
        logic [31:0] pc;
        logic [31:0] npc;
        logic [31:0] value;
        bit          done;
        bit          br;
    } ent_t;

    ent_t q[$];
    int   tail_tag = 0;
    int   errors = 0;
    int   checks = 0;

    task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic clear_inputs();
        reset           = 1'b1;
        flush           = 1'b0;
        dp_valid        = '0;
        dp_dest_reg     = 10'($urandom);
        dp_pc           = {$urandom, $urandom};
        cdb_valid       = '0;
        cdb_tag         = '0;
        cdb_value       = '0;
        cdb_npc         = '0;
        cdb_take_branch = '0;
        src_tag         = 20'($urandom);
    endtask

    task automatic set_cdb(input int p, input int tag, input logic [31:0] val,
                           input logic [31:0] npc, input logic br);
        cdb_valid[p]              = 1'b1;
        cdb_tag[p*TAG_W +: TAG_W] = 5'(tag);
        cdb_value[p*XLEN +: XLEN] = val;
        cdb_npc[p*XLEN +: XLEN]   = npc;
        cdb_take_branch[p]        = br;
    endtask

    // One checked clock cycle: compare outputs against the model, clock, then advance the model.
    task automatic apply_stimulus();
        int          n;
        int          nret;
        bit          exp_rdy;
        logic [1:0]  ert;
        logic        esq;
        logic [31:0] espc;
        logic [9:0]  etag;
        logic        eready;
        logic [31:0] evalue;
        int          t;
        ent_t        e;
        #1;
        n = q.size();
        check_output("count", 64'(count), 64'(n));
        check_output("empty", 64'(empty), 64'(n == 0));
        check_output("full", 64'(full), 64'(n == DEPTH));
        exp_rdy = (DEPTH - n) >= WIDTH;
        check_output("dp_ready", 64'(dp_ready), 64'(exp_rdy));
        etag = {5'((tail_tag + 1) % DEPTH), 5'(tail_tag % DEPTH)};
        check_output("dp_tag", 64'(dp_tag), 64'(etag));
        ert  = '0;
        esq  = 1'b0;
        espc = '0;
        nret = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i >= n) break;
            if (!q[i].done) break;
            ert[i] = 1'b1;
            nret++;
            if (reset) begin
                check_output("rt_pc", 64'(rt_pc[i*XLEN +: XLEN]), 64'(q[i].pc));
                check_output("rt_value", 64'(rt_value[i*XLEN +: XLEN]), 64'(q[i].value));
                check_output("rt_dest_reg", 64'(rt_dest_reg[i*5 +: 5]), 64'(q[i].dest));
            end
            if (q[i].br) begin
                esq  = 1'b1;
                espc = q[i].npc;
                break;
            end
        end
        check_output("rt_valid", 64'(rt_valid), reset ? 64'(ert) : 64'(0));
        check_output("squash", 64'(squash), 64'(reset && esq));
        check_output("squash_pc", 64'(squash_pc), reset ? 64'(espc) : 64'(0));
        for (int s = 0; s < NSRC; s++) begin
            t = int'(src_tag[s*TAG_W +: TAG_W]);
            eready = 1'b0;
            evalue = '0;
            foreach (q[j]) begin
                if (q[j].tag == t && q[j].done) begin
                    eready = 1'b1;
                    evalue = q[j].value;
                end
            end
            for (int p = 0; p < CDB_PORTS; p++) begin
                if (cdb_valid[p] && int'(cdb_tag[p*TAG_W +: TAG_W]) == t) begin
                    eready = 1'b1;
                    evalue = cdb_value[p*XLEN +: XLEN];
                end
            end
            check_output("src_ready", 64'(src_ready[s]), 64'(eready));
            if (eready) check_output("src_value", 64'(src_value[s*XLEN +: XLEN]), 64'(evalue));
        end
        @(posedge clock);
        if (!reset || flush || esq) begin
            q.delete();
            tail_tag = 0;
        end else begin
            for (int p = 0; p < CDB_PORTS; p++) begin
                if (cdb_valid[p]) begin
                    foreach (q[j]) begin
                        if (q[j].tag == int'(cdb_tag[p*TAG_W +: TAG_W])) begin
                            q[j].done  = 1'b1;
                            q[j].br    = cdb_take_branch[p];
                            q[j].value = cdb_value[p*XLEN +: XLEN];
                            q[j].npc   = cdb_npc[p*XLEN +: XLEN];
                        end
                    end
                end
            end
            repeat (nret) void'(q.pop_front());
            if (exp_rdy) begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (!dp_valid[i]) break;
                    e.tag   = tail_tag;
                    e.dest  = dp_dest_reg[i*5 +: 5];
                    e.pc    = dp_pc[i*XLEN +: XLEN];
                    e.npc   = '0;
                    e.value = '0;
                    e.done  = 1'b0;
                    e.br    = 1'b0;
                    q.push_back(e);
                    tail_tag = (tail_tag + 1) % DEPTH;
                end
            end
        end
        @(negedge clock);
    endtask

    task automatic reset_cycle();
        clear_inputs();
        reset = 1'b0;
        apply_stimulus();
        clear_inputs();
    endtask

    task automatic random_cycle();
        int r;
        int t;
        clear_inputs();
        r = int'($urandom_range(0, 3));
        dp_valid = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
        for (int p = 0; p < CDB_PORTS; p++) begin
            if ($urandom_range(0, 9) < 6) begin
                if (q.size() > 0 && $urandom_range(0, 6) != 0)
                    t = q[$urandom_range(0, q.size() - 1)].tag;
                else
                    t = int'($urandom_range(0, DEPTH - 1));
                if (p == 1 && cdb_valid[0] && int'(cdb_tag[4:0]) == t) continue;
                set_cdb(p, t, $urandom, $urandom, $urandom_range(0, 24) == 0);
            end
        end
        for (int s = 0; s < NSRC; s++) begin
            if ($urandom_range(0, 2) == 0 && cdb_valid[0])
                src_tag[s*TAG_W +: TAG_W] = cdb_tag[4:0];
            else if (q.size() > 0 && $urandom_range(0, 1) == 0)
                src_tag[s*TAG_W +: TAG_W] = 5'(q[$urandom_range(0, q.size() - 1)].tag);
        end
        flush = ($urandom_range(0, 99) == 0);
        reset = !($urandom_range(0, 199) == 0);
        apply_stimulus();
    endtask

    initial begin
        clear_inputs();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset_cycle();
        check_output("rst_empty", 64'(empty), 64'(1));
        check_output("rst_full", 64'(full), 64'(0));
        check_output("rst_dp_ready", 64'(dp_ready), 64'(1));
        check_output("rst_dp_tag", 64'(dp_tag), 64'h20);
        check_output("rst_rt_valid", 64'(rt_valid), 64'(0));
        check_output("rst_squash_pc", 64'(squash_pc), 64'(0));

        repeat (16) begin
            clear_inputs();
            dp_valid = 2'b11;
            apply_stimulus();
        end
        check_output("fill_full", 64'(full), 64'(1));
        check_output("fill_count", 64'(count), 64'(32));
        check_output("fill_dp_ready", 64'(dp_ready), 64'(0));

        clear_inputs();
        set_cdb(0, 1, 32'h11, 32'h0, 1'b0);
        apply_stimulus();
        check_output("ooo_no_retire", 64'(rt_valid), 64'(0));
        clear_inputs();
        set_cdb(0, 0, 32'h10, 32'h0, 1'b0);
        apply_stimulus();
        check_output("ooo_retire2", 64'(rt_valid), 64'(2'b11));
        clear_inputs();
        apply_stimulus();
        check_output("ooo_count", 64'(count), 64'(30));

        reset_cycle();
        dp_valid = 2'b11;
        apply_stimulus();
        clear_inputs();
        set_cdb(0, 0, 32'haa, 32'h100, 1'b1);
        set_cdb(1, 1, 32'hbb, 32'h200, 1'b0);
        apply_stimulus();
        check_output("br_rt_valid", 64'(rt_valid), 64'(2'b01));
        check_output("br_squash", 64'(squash), 64'(1));
        check_output("br_squash_pc", 64'(squash_pc), 64'h100);
        clear_inputs();
        dp_valid = 2'b11;
        apply_stimulus();
        check_output("br_count", 64'(count), 64'(0));
        check_output("br_empty", 64'(empty), 64'(1));

        reset_cycle();
        repeat (3) begin
            clear_inputs();
            dp_valid = 2'b11;
            apply_stimulus();
        end
        clear_inputs();
        set_cdb(0, 5, 32'hdeadbeef, 32'h0, 1'b0);
        src_tag[4:0] = 5'd5;
        #1;
        check_output("byp_ready", 64'(src_ready[0]), 64'(1));
        check_output("byp_value", 64'(src_value[31:0]), 64'hdeadbeef);
        apply_stimulus();

        clear_inputs();
        dp_valid = 2'b11;
        flush = 1'b1;
        reset = 1'b0;
        apply_stimulus();
        check_output("fr_count", 64'(count), 64'(0));
        check_output("fr_rt_valid", 64'(rt_valid), 64'(0));
        check_output("fr_dp_tag", 64'(dp_tag), 64'h20);
        clear_inputs();
        dp_valid = 2'b11;
        apply_stimulus();
        clear_inputs();
        dp_valid = 2'b11;
        flush = 1'b1;
        apply_stimulus();
        check_output("flush_count", 64'(count), 64'(0));

        reset_cycle();
        repeat (15) begin
            clear_inputs();
            dp_valid = 2'b11;
            apply_stimulus();
        end
        for (int k = 0; k < 15; k++) begin
            clear_inputs();
            set_cdb(0, 2*k, $urandom, 32'h0, 1'b0);
            set_cdb(1, 2*k + 1, $urandom, 32'h0, 1'b0);
            apply_stimulus();
        end
        repeat (16) begin
            clear_inputs();
            apply_stimulus();
        end
        repeat (15) begin
            clear_inputs();
            dp_valid = 2'b11;
            apply_stimulus();
        end
        clear_inputs();
        dp_valid = 2'b01;
        apply_stimulus();
        check_output("wrap_count", 64'(count), 64'(31));
        check_output("wrap_dp_ready", 64'(dp_ready), 64'(0));
        check_output("wrap_dp_tag", 64'(dp_tag), 64'h3dd);
        clear_inputs();
        set_cdb(0, 30, 32'h30, 32'h0, 1'b0);
        apply_stimulus();
        check_output("wrap_rt_valid", 64'(rt_valid), 64'(2'b01));
        clear_inputs();
        apply_stimulus();
        check_output("wrap_count2", 64'(count), 64'(30));
        check_output("wrap_dp_ready2", 64'(dp_ready), 64'(1));

        repeat (1500) random_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
